// File: rtl/mac_table_sched_pkg.sv
// Shared constants, FSM state encoding and helpers for the MAC learning table scheduler.
package mac_table_sched_pkg;
    localparam int          MAC_WIDTH      = 48;
    localparam int          PORT_WIDTH_DEF = 16;
    localparam logic [15:0] FLOOD_MASK_DEF = 16'h0055;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_LEARN_SRCH,
        ST_LEARN_WR,
        ST_AGE
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/mac_table_sched_if.sv
// Lookup and learn request/acknowledge bundle between the port-lookup stage and the table scheduler.
interface mac_table_sched_if #(
    parameter int PORT_WIDTH = 16
);
    import mac_table_sched_pkg::*;

    logic                  lkup_req;
    logic [MAC_WIDTH-1:0]  lkup_mac;
    logic [PORT_WIDTH-1:0] lkup_src_port;
    logic                  lkup_ack;
    logic                  lkup_hit;
    logic [PORT_WIDTH-1:0] lkup_port;
    logic                  learn_req;
    logic [MAC_WIDTH-1:0]  learn_mac;
    logic [PORT_WIDTH-1:0] learn_port;
    logic                  learn_ack;

    modport master (
        output lkup_req, lkup_mac, lkup_src_port, learn_req, learn_mac, learn_port,
        input  lkup_ack, lkup_hit, lkup_port, learn_ack
    );

    modport slave (
        input  lkup_req, lkup_mac, lkup_src_port, learn_req, learn_mac, learn_port,
        output lkup_ack, lkup_hit, lkup_port, learn_ack
    );
endinterface

// File: rtl/mac_table_sched_entries.sv
// Entry storage (valid, active, mac, port) with an all-entries parallel compare against one key.
module mac_table_sched_entries
    import mac_table_sched_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int PORT_WIDTH  = 16,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [MAC_WIDTH-1:0]  key,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [MAC_WIDTH-1:0]  wr_mac,
    input  logic [PORT_WIDTH-1:0] wr_port,
    input  logic                  act_en,
    input  logic [IDX_W-1:0]      act_idx,
    input  logic                  age_en,
    input  logic [IDX_W-1:0]      age_idx,
    output logic                  match,
    output logic [IDX_W-1:0]      match_idx,
    output logic [PORT_WIDTH-1:0] match_port,
    output logic [IDX_W-1:0]      first_free_idx,
    output logic                  any_free,
    output logic                  full
);
    logic [NUM_ENTRIES-1:0] valid_vec;
    logic [NUM_ENTRIES-1:0] hit_vec;
    logic [PORT_WIDTH-1:0]  port_vec [NUM_ENTRIES];
    logic                   full_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_ent
            logic                  valid_q, valid_d;
            logic                  active_q, active_d;
            logic [MAC_WIDTH-1:0]  mac_q;
            logic [PORT_WIDTH-1:0] port_q;
            logic                  sel_wr, sel_act, sel_age;

            assign sel_wr  = wr_en  && (wr_idx  == IDX_W'(gi));
            assign sel_act = act_en && (act_idx == IDX_W'(gi));
            assign sel_age = age_en && (age_idx == IDX_W'(gi));

            // An aging visit first demotes an active entry, and only evicts it on the next visit.
            always_comb begin
                valid_d  = valid_q;
                active_d = active_q;
                if (sel_age) begin
                    if (active_q) active_d = 1'b0;
                    else          valid_d  = 1'b0;
                end
                if (sel_act) active_d = 1'b1;
                if (sel_wr) begin
                    valid_d  = 1'b1;
                    active_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_q  <= 1'b0;
                    active_q <= 1'b0;
                end else begin
                    valid_q  <= valid_d;
                    active_q <= active_d;
                end
            end

            always_ff @(posedge clk) begin
                if (sel_wr) begin
                    mac_q  <= wr_mac;
                    port_q <= wr_port;
                end
            end

            assign valid_vec[gi] = valid_q;
            assign hit_vec[gi]   = valid_q && (mac_q == key);
            assign port_vec[gi]  = port_q;
        end
    endgenerate

    // Learns update in place, so at most one hit bit is set and OR-reduction is exact.
    always_comb begin
        match_idx      = '0;
        match_port     = '0;
        first_free_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (hit_vec[i]) begin
                match_idx  = match_idx | IDX_W'(i);
                match_port = match_port | port_vec[i];
            end
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) first_free_idx = IDX_W'(i);
        end
    end

    assign match    = |hit_vec;
    assign any_free = ~&valid_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) full_q <= 1'b0;
        else        full_q <= &valid_vec;
    end

    assign full = full_q;
endmodule

// File: rtl/mac_table_sched.sv
// MAC learning table owner: arbitrates lookups, learns and the aging sweep onto one table.
module mac_table_sched
    import mac_table_sched_pkg::*;
#(
    parameter int                    NUM_ENTRIES = 16,
    parameter int                    PORT_WIDTH  = PORT_WIDTH_DEF,
    parameter logic [PORT_WIDTH-1:0] FLOOD_MASK  = FLOOD_MASK_DEF,
    parameter logic [31:0]           AGE_PERIOD  = 32'd125000
) (
    input  logic              clk,
    input  logic              reset,
    mac_table_sched_if.slave  bus,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic              table_full
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    state_t                state_q, state_d;
    logic                  last_lkup_q, last_lkup_d;
    logic [MAC_WIDTH-1:0]  key_q, key_d;
    logic [PORT_WIDTH-1:0] kport_q, kport_d;
    logic [IDX_W-1:0]      tgt_idx_q, tgt_idx_d;
    logic                  bump_ptr_q, bump_ptr_d;
    logic [IDX_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [31:0]           age_cnt_q, age_cnt_d;
    logic                  age_pend_q, age_pend_d;
    logic [IDX_W-1:0]      sweep_idx_q, sweep_idx_d;
    logic                  lkup_ack_q, lkup_ack_d;
    logic                  lkup_hit_q, lkup_hit_d;
    logic [PORT_WIDTH-1:0] lkup_port_q, lkup_port_d;
    logic                  learn_ack_q, learn_ack_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;

    logic                  match, any_free, age_tick, lk_pend, ln_pend;
    logic [IDX_W-1:0]      match_idx, first_free_idx;
    logic [PORT_WIDTH-1:0] match_port;

    mac_table_sched_entries #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .PORT_WIDTH  (PORT_WIDTH),
        .IDX_W       (IDX_W)
    ) u_entries (
        .clk            (clk),
        .reset          (reset),
        .key            (key_q),
        .wr_en          (state_q == ST_LEARN_WR),
        .wr_idx         (tgt_idx_q),
        .wr_mac         (key_q),
        .wr_port        (kport_q),
        .act_en         ((state_q == ST_LOOKUP) && match),
        .act_idx        (match_idx),
        .age_en         (state_q == ST_AGE),
        .age_idx        (sweep_idx_q),
        .match          (match),
        .match_idx      (match_idx),
        .match_port     (match_port),
        .first_free_idx (first_free_idx),
        .any_free       (any_free),
        .full           (table_full)
    );

    // A request is still high during its own ack cycle; it must not be served twice.
    assign lk_pend  = bus.lkup_req  && !lkup_ack_q;
    assign ln_pend  = bus.learn_req && !learn_ack_q;
    assign age_tick = (age_cnt_q == AGE_PERIOD - 32'd1);

    always_comb begin
        state_d     = state_q;
        last_lkup_d = last_lkup_q;
        key_d       = key_q;
        kport_d     = kport_q;
        tgt_idx_d   = tgt_idx_q;
        bump_ptr_d  = bump_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        sweep_idx_d = sweep_idx_q;
        lkup_ack_d  = 1'b0;
        lkup_hit_d  = lkup_hit_q;
        lkup_port_d = lkup_port_q;
        learn_ack_d = 1'b0;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        age_cnt_d   = age_tick ? 32'd0 : age_cnt_q + 32'd1;
        age_pend_d  = age_pend_q;
        if (age_tick && !age_pend_q) age_pend_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (lk_pend && (!ln_pend || !last_lkup_q)) begin
                    state_d     = ST_LOOKUP;
                    key_d       = bus.lkup_mac;
                    kport_d     = bus.lkup_src_port;
                    last_lkup_d = 1'b1;
                end else if (ln_pend) begin
                    state_d     = ST_LEARN_SRCH;
                    key_d       = bus.learn_mac;
                    kport_d     = bus.learn_port;
                    last_lkup_d = 1'b0;
                end else if (age_pend_q) begin
                    state_d = ST_AGE;
                end
            end
            ST_LOOKUP: begin
                state_d     = ST_IDLE;
                lkup_ack_d  = 1'b1;
                lkup_hit_d  = match;
                lkup_port_d = match ? match_port : (FLOOD_MASK & ~kport_q);
                if (match) hit_cnt_d  = sat_inc16(hit_cnt_q);
                else       miss_cnt_d = sat_inc16(miss_cnt_q);
            end
            ST_LEARN_SRCH: begin
                state_d    = ST_LEARN_WR;
                tgt_idx_d  = match ? match_idx : (any_free ? first_free_idx : wr_ptr_q);
                bump_ptr_d = !match && !any_free;
            end
            ST_LEARN_WR: begin
                state_d     = ST_IDLE;
                learn_ack_d = 1'b1;
                if (bump_ptr_q) wr_ptr_d = wr_ptr_q + IDX_W'(1);
            end
            ST_AGE: begin
                state_d     = ST_IDLE;
                sweep_idx_d = sweep_idx_q + IDX_W'(1);
                if (sweep_idx_q == IDX_W'(NUM_ENTRIES - 1)) age_pend_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_lkup_q <= 1'b0;
            key_q       <= '0;
            kport_q     <= '0;
            tgt_idx_q   <= '0;
            bump_ptr_q  <= 1'b0;
            wr_ptr_q    <= '0;
            age_cnt_q   <= '0;
            age_pend_q  <= 1'b0;
            sweep_idx_q <= '0;
            lkup_ack_q  <= 1'b0;
            lkup_hit_q  <= 1'b0;
            lkup_port_q <= '0;
            learn_ack_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_lkup_q <= last_lkup_d;
            key_q       <= key_d;
            kport_q     <= kport_d;
            tgt_idx_q   <= tgt_idx_d;
            bump_ptr_q  <= bump_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            age_cnt_q   <= age_cnt_d;
            age_pend_q  <= age_pend_d;
            sweep_idx_q <= sweep_idx_d;
            lkup_ack_q  <= lkup_ack_d;
            lkup_hit_q  <= lkup_hit_d;
            lkup_port_q <= lkup_port_d;
            learn_ack_q <= learn_ack_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.lkup_ack  = lkup_ack_q;
    assign bus.lkup_hit  = lkup_hit_q;
    assign bus.lkup_port = lkup_port_q;
    assign bus.learn_ack = learn_ack_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
endmodule

// File: tb/tb_mac_table_sched.sv
// Directed bench: one main table (no aging in range) plus one table with a short aging period.
module tb_mac_table_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_table_sched_if bus ();
    mac_table_sched_if abus ();

    logic [15:0] hit_count, miss_count, a_hit_count, a_miss_count;
    logic        table_full, a_table_full;

    mac_table_sched dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .table_full (table_full)
    );

    mac_table_sched #(.AGE_PERIOD(32'd64)) dut_age (
        .clk        (clk),
        .reset      (reset),
        .bus        (abus),
        .hit_count  (a_hit_count),
        .miss_count (a_miss_count),
        .table_full (a_table_full)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [47:0] MB = 48'h0200_0000_0000;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_lookup(input bit sel, input logic [47:0] mac, input logic [15:0] src,
                             output logic hit, output logic [15:0] port, output int lat);
        logic ack;
        lat = 0;
        ack = 1'b0;
        if (sel) begin
            abus.lkup_mac = mac; abus.lkup_src_port = src; abus.lkup_req = 1'b1;
        end else begin
            bus.lkup_mac = mac; bus.lkup_src_port = src; bus.lkup_req = 1'b1;
        end
        while (!ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            ack = sel ? abus.lkup_ack : bus.lkup_ack;
        end
        hit  = sel ? abus.lkup_hit : bus.lkup_hit;
        port = sel ? abus.lkup_port : bus.lkup_port;
        if (sel) abus.lkup_req = 1'b0;
        else     bus.lkup_req  = 1'b0;
        chk("lkup_ack_seen", 48'(ack), 48'h1);
        $display("lookup dut=%0d mac=%h src=%h -> hit=%0b port=%h latency=%0d", sel, mac, src, hit, port, lat);
    endtask

    task automatic do_learn(input bit sel, input logic [47:0] mac, input logic [15:0] port, output int lat);
        logic ack;
        lat = 0;
        ack = 1'b0;
        if (sel) begin
            abus.learn_mac = mac; abus.learn_port = port; abus.learn_req = 1'b1;
        end else begin
            bus.learn_mac = mac; bus.learn_port = port; bus.learn_req = 1'b1;
        end
        while (!ack && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            ack = sel ? abus.learn_ack : bus.learn_ack;
        end
        if (sel) abus.learn_req = 1'b0;
        else     bus.learn_req  = 1'b0;
        chk("learn_ack_seen", 48'(ack), 48'h1);
        $display("learn  dut=%0d mac=%h port=%h latency=%0d", sel, mac, port, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        hit;
        logic [15:0] port;
        int          lat;
        int          n_acks;
        int          cyc;
        logic        expect_learn;
        logic        seen;

        reset = 1'b0;
        bus.lkup_req = 1'b0;  bus.lkup_mac = '0;  bus.lkup_src_port = '0;
        bus.learn_req = 1'b0; bus.learn_mac = '0; bus.learn_port = '0;
        abus.lkup_req = 1'b0;  abus.lkup_mac = '0;  abus.lkup_src_port = '0;
        abus.learn_req = 1'b0; abus.learn_mac = '0; abus.learn_port = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_lkup_ack",  48'(bus.lkup_ack), 48'h0);
        chk("rst_learn_ack", 48'(bus.learn_ack), 48'h0);
        chk("rst_lkup_hit",  48'(bus.lkup_hit), 48'h0);
        chk("rst_lkup_port", 48'(bus.lkup_port), 48'h0);
        chk("rst_hit_cnt",   48'(hit_count), 48'h0);
        chk("rst_miss_cnt",  48'(miss_count), 48'h0);
        chk("rst_full",      48'(table_full), 48'h0);
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: miss on empty table floods minus ingress port
        do_lookup(0, 48'hAABB_CC00_0001, 16'h0004, hit, port, lat);
        chk("t1_latency", 48'(lat), 48'd2);
        chk("t1_hit", 48'(hit), 48'h0);
        chk("t1_port", 48'(port), 48'h0051);
        chk("t1_miss_cnt", 48'(miss_count), 48'd1);
        chk("t1_hit_cnt", 48'(hit_count), 48'd0);

        // 2: learn then lookup
        do_learn(0, 48'h0000_0000_0005, 16'h0010, lat);
        chk("t2_learn_latency", 48'(lat), 48'd3);
        do_lookup(0, 48'h0000_0000_0005, 16'h0001, hit, port, lat);
        chk("t2_latency", 48'(lat), 48'd2);
        chk("t2_hit", 48'(hit), 48'h1);
        chk("t2_port", 48'(port), 48'h0010);
        chk("t2_hit_cnt", 48'(hit_count), 48'd1);
        chk("t2_miss_cnt", 48'(miss_count), 48'd1);

        // 5: aging on the short-period table; A kept alive by lookups, B left to expire
        do_learn(1, 48'h0A00_0000_0001, 16'h0002, lat);
        do_learn(1, 48'h0A00_0000_0002, 16'h0008, lat);
        for (int k = 0; k < 10; k++) begin
            do_lookup(1, 48'h0A00_0000_0001, 16'h0001, hit, port, lat);
            chk("t5_a_hit", 48'(hit), 48'h1);
            repeat (20) @(posedge clk);
            #1;
        end
        do_lookup(1, 48'h0A00_0000_0001, 16'h0001, hit, port, lat);
        chk("t5_a_final_hit", 48'(hit), 48'h1);
        chk("t5_a_port", 48'(port), 48'h0002);
        do_lookup(1, 48'h0A00_0000_0002, 16'h0001, hit, port, lat);
        chk("t5_b_miss", 48'(hit), 48'h0);
        chk("t5_b_port", 48'(port), 48'h0054);
        chk("t5_hit_cnt", 48'(a_hit_count), 48'd11);
        chk("t5_miss_cnt", 48'(a_miss_count), 48'd1);

        // 3: fill the table and overflow it
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("t3_rst_hit_cnt", 48'(hit_count), 48'd0);
        for (int i = 0; i < 17; i++) begin
            logic [15:0] p;
            p = 16'h0001 << (i % 16);
            do_learn(0, MB + 48'(i), p, lat);
            if (i == 14) begin
                @(posedge clk); #1;
                chk("t3_not_full_15", 48'(table_full), 48'h0);
            end
            if (i == 15) begin
                @(posedge clk); #1;
                chk("t3_full_16", 48'(table_full), 48'h1);
            end
        end
        do_lookup(0, MB + 48'd0, 16'h0010, hit, port, lat);
        chk("t3_mac0_miss", 48'(hit), 48'h0);
        chk("t3_mac0_port", 48'(port), 48'h0045);
        do_lookup(0, MB + 48'd16, 16'h0010, hit, port, lat);
        chk("t3_mac16_hit", 48'(hit), 48'h1);
        chk("t3_mac16_port", 48'(port), 48'h0001);
        do_lookup(0, MB + 48'd1, 16'h0010, hit, port, lat);
        chk("t3_mac1_port", 48'(port), 48'h0002);
        // in-place update must not advance the replacement pointer
        do_learn(0, MB + 48'd1, 16'h0100, lat);
        do_lookup(0, MB + 48'd1, 16'h0010, hit, port, lat);
        chk("t3_update_port", 48'(port), 48'h0100);
        do_learn(0, MB + 48'd17, 16'h0002, lat);
        do_lookup(0, MB + 48'd1, 16'h0010, hit, port, lat);
        chk("t3_ptr1_evict", 48'(hit), 48'h0);
        do_lookup(0, MB + 48'd17, 16'h0010, hit, port, lat);
        chk("t3_mac17_port", 48'(port), 48'h0002);
        do_lookup(0, MB + 48'd2, 16'h0010, hit, port, lat);
        chk("t3_mac2_port", 48'(port), 48'h0004);
        chk("t3_full_kept", 48'(table_full), 48'h1);

        // 4: both requests held; last served was a lookup, so learn goes first
        bus.lkup_mac = MB + 48'd2;  bus.lkup_src_port = 16'h0001;
        bus.learn_mac = MB + 48'd3; bus.learn_port = 16'h0008;
        bus.lkup_req = 1'b1;
        bus.learn_req = 1'b1;
        n_acks = 0;
        cyc = 0;
        expect_learn = 1'b1;
        while (n_acks < 12 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (bus.lkup_ack || bus.learn_ack) begin
                chk("t4_single_ack", 48'(bus.lkup_ack & bus.learn_ack), 48'h0);
                chk("t4_order", 48'(bus.learn_ack), 48'(expect_learn));
                $display("ack #%0d kind=%s cycle=%0d", n_acks, bus.learn_ack ? "learn" : "lookup", cyc);
                expect_learn = !expect_learn;
                n_acks++;
            end
        end
        chk("t4_ack_count", 48'(n_acks), 48'd12);
        chk("t4_cycles", 48'(cyc <= 35), 48'h1);
        bus.lkup_req = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            seen = bus.learn_ack;
        end
        bus.learn_req = 1'b0;
        chk("t4_drain_learn", 48'(seen), 48'h1);
        @(posedge clk); #1;

        // 6: reset while the learn is in its search cycle
        bus.learn_mac = MB + 48'd40;
        bus.learn_port = 16'h0001;
        bus.learn_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.learn_req = 1'b0;
        #1;
        chk("t6_hit_cnt", 48'(hit_count), 48'd0);
        chk("t6_miss_cnt", 48'(miss_count), 48'd0);
        chk("t6_full", 48'(table_full), 48'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.learn_ack) seen = 1'b1;
        end
        chk("t6_no_learn_ack", 48'(seen), 48'h0);
        do_lookup(0, MB + 48'd16, 16'h0004, hit, port, lat);
        chk("t6_lookup_miss", 48'(hit), 48'h0);
        chk("t6_lookup_port", 48'(port), 48'h0051);
        chk("t6_miss_cnt_after", 48'(miss_count), 48'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
